// File: rtl/lcd1602_responder.sv
// HD44780-style responder for the 16x2 LCD bus: latches rs/rw/data/en transactions,
// decodes the instruction set and maintains DDRAM, CGRAM, address counter and busy flag.
module lcd1602_responder #(
    parameter int unsigned BUSY_CYCLES_CMD  = 40,
    parameter int unsigned BUSY_CYCLES_HOME = 1600,
    parameter int unsigned SYNC_STAGES      = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       lcd_en,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic [7:0] lcd_data_in,
    output logic [7:0] lcd_data_out,
    output logic       busy,
    output logic [6:0] ac,
    output logic       ac_is_cgram,
    output logic       display_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic       entry_inc,
    output logic       two_line,
    output logic       mode_8bit,
    output logic       overrun,
    input  logic [6:0] dbg_ddram_addr,
    output logic [7:0] dbg_ddram_data,
    input  logic [5:0] dbg_cgram_addr,
    output logic [7:0] dbg_cgram_data
);

    localparam int unsigned CNT_W = $clog2(BUSY_CYCLES_HOME + BUSY_CYCLES_CMD + 1);
    localparam logic [6:0]  FILL_LAST = 7'd79;

    typedef enum logic [1:0] {IDLE, EXEC, BUSY, CLEAR_FILL} state_t;

    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic [6:0]             fill_idx;
    logic                   lat_rs;
    logic [7:0]             lat_data;
    logic [SYNC_STAGES-1:0] en_sync;
    logic                   en_prev;
    logic                   en_rise;
    logic                   en_fall;

    logic [7:0] ddram [80];
    logic [7:0] cgram [64];

    logic       dd_we;
    logic       cg_we;
    logic [6:0] dd_waddr;
    logic [7:0] ram_wdata;

    function automatic logic dd_valid(input logic [6:0] a);
        return (a <= 7'h27) || (a >= 7'h40 && a <= 7'h67);
    endfunction

    // Second display line (0x40-0x67) packs directly after the first 40 cells.
    function automatic logic [6:0] dd_index(input logic [6:0] a);
        return (a < 7'h40) ? a : a - 7'h18;
    endfunction

    function automatic logic [6:0] step_ac(input logic [6:0] a, input logic cg, input logic inc);
        logic [6:0] r;
        if (cg) begin
            r = {1'b0, inc ? a[5:0] + 6'd1 : a[5:0] - 6'd1};
        end else if (inc) begin
            if (a < 7'h27 || (a >= 7'h40 && a < 7'h67)) r = a + 7'd1;
            else if (a < 7'h40)                          r = 7'h40;
            else                                         r = 7'h00;
        end else begin
            if ((a > 7'h00 && a <= 7'h27) || (a > 7'h40 && a <= 7'h67)) r = a - 7'd1;
            else if (a >= 7'h28 && a <= 7'h40)                          r = 7'h27;
            else                                                        r = 7'h67;
        end
        return r;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            en_sync <= '0;
            en_prev <= 1'b0;
        end else begin
            en_sync[0] <= lcd_en;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) en_sync[i] <= en_sync[i-1];
            en_prev <= en_sync[SYNC_STAGES-1];
        end
    end

    assign en_rise = en_sync[SYNC_STAGES-1] & ~en_prev;
    assign en_fall = ~en_sync[SYNC_STAGES-1] & en_prev;

    always_comb begin
        dd_we     = 1'b0;
        cg_we     = 1'b0;
        dd_waddr  = '0;
        ram_wdata = '0;
        if (state == CLEAR_FILL) begin
            dd_we     = 1'b1;
            dd_waddr  = fill_idx;
            ram_wdata = 8'h20;
        end else if (state == EXEC && lat_rs) begin
            ram_wdata = lat_data;
            if (ac_is_cgram) begin
                cg_we = 1'b1;
            end else if (dd_valid(ac)) begin
                dd_we    = 1'b1;
                dd_waddr = dd_index(ac);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (dd_we) ddram[dd_waddr] <= ram_wdata;
        if (cg_we) cgram[ac[5:0]] <= ram_wdata;
    end

    always_comb begin
        dbg_ddram_data = dd_valid(dbg_ddram_addr) ? ddram[dd_index(dbg_ddram_addr)] : '0;
        dbg_cgram_data = cgram[dbg_cgram_addr];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            cnt          <= '0;
            fill_idx     <= '0;
            lat_rs       <= 1'b0;
            lat_data     <= '0;
            lcd_data_out <= '0;
            busy         <= 1'b0;
            ac           <= '0;
            ac_is_cgram  <= 1'b0;
            display_on   <= 1'b0;
            cursor_on    <= 1'b0;
            blink_on     <= 1'b0;
            entry_inc    <= 1'b1;
            two_line     <= 1'b0;
            mode_8bit    <= 1'b1;
            overrun      <= 1'b0;
        end else begin
            overrun <= 1'b0;

            // Status reads are always served; data reads only when idle.
            if (en_rise && lcd_rw) begin
                if (!lcd_rs)          lcd_data_out <= {busy, ac};
                else if (busy)        overrun      <= 1'b1;
                else if (ac_is_cgram) lcd_data_out <= cgram[ac[5:0]];
                else if (dd_valid(ac)) lcd_data_out <= ddram[dd_index(ac)];
                else                  lcd_data_out <= '0;
            end

            case (state)
                IDLE: begin
                    if (en_fall) begin
                        if (!lcd_rw) begin
                            lat_rs   <= lcd_rs;
                            lat_data <= lcd_data_in;
                            busy     <= 1'b1;
                            state    <= EXEC;
                        end else if (lcd_rs) begin
                            ac <= step_ac(ac, ac_is_cgram, entry_inc);
                        end
                    end
                end

                EXEC: begin
                    state <= BUSY;
                    cnt   <= CNT_W'(BUSY_CYCLES_CMD - 1);
                    if (lat_rs) begin
                        ac <= step_ac(ac, ac_is_cgram, entry_inc);
                    end else begin
                        casez (lat_data)
                            8'b1???????: begin
                                ac          <= lat_data[6:0];
                                ac_is_cgram <= 1'b0;
                            end
                            8'b01??????: begin
                                ac          <= {1'b0, lat_data[5:0]};
                                ac_is_cgram <= 1'b1;
                            end
                            8'b001?????: begin
                                mode_8bit <= lat_data[4];
                                two_line  <= lat_data[3];
                            end
                            8'b0001????: begin
                                if (!lat_data[3]) ac <= step_ac(ac, ac_is_cgram, lat_data[2]);
                            end
                            8'b00001???: begin
                                display_on <= lat_data[2];
                                cursor_on  <= lat_data[1];
                                blink_on   <= lat_data[0];
                            end
                            8'b000001??: entry_inc <= lat_data[1];
                            8'b0000001?: begin
                                ac          <= '0;
                                ac_is_cgram <= 1'b0;
                                cnt         <= CNT_W'(BUSY_CYCLES_HOME - 1);
                            end
                            8'b00000001: begin
                                ac          <= '0;
                                ac_is_cgram <= 1'b0;
                                entry_inc   <= 1'b1;
                                cnt         <= CNT_W'(BUSY_CYCLES_HOME - 1);
                                fill_idx    <= '0;
                                state       <= CLEAR_FILL;
                            end
                            default: ;
                        endcase
                    end
                end

                // The fill consumes part of the clear's busy budget, one cell per clock.
                CLEAR_FILL: begin
                    fill_idx <= fill_idx + 7'd1;
                    cnt      <= cnt - 1'b1;
                    if (fill_idx == FILL_LAST) begin
                        if (cnt == '0) begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            state <= BUSY;
                        end
                    end
                end

                BUSY: begin
                    if (cnt == '0) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase

            if (state != IDLE && en_fall && !lcd_rw) overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_lcd1602_responder.sv
// Bench for lcd1602_responder: directed table, clear/reset corner cases, then random
// bus traffic checked against an address-level model of the LCD controller.
module tb_lcd1602_responder;

    localparam int unsigned CMD  = 40;
    localparam int unsigned HOME = 1600;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       lcd_en = 1'b0;
    logic       lcd_rs = 1'b0;
    logic       lcd_rw = 1'b0;
    logic [7:0] lcd_data_in = '0;
    logic [7:0] lcd_data_out;
    logic       busy;
    logic [6:0] ac;
    logic       ac_is_cgram, display_on, cursor_on, blink_on, entry_inc, two_line, mode_8bit;
    logic       overrun;
    logic [6:0] dbg_ddram_addr = '0;
    logic [7:0] dbg_ddram_data;
    logic [5:0] dbg_cgram_addr = '0;
    logic [7:0] dbg_cgram_data;

    lcd1602_responder #(
        .BUSY_CYCLES_CMD (CMD),
        .BUSY_CYCLES_HOME(HOME),
        .SYNC_STAGES     (2)
    ) dut (
        .clk(clk), .reset(reset), .lcd_en(lcd_en), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
        .lcd_data_in(lcd_data_in), .lcd_data_out(lcd_data_out), .busy(busy), .ac(ac),
        .ac_is_cgram(ac_is_cgram), .display_on(display_on), .cursor_on(cursor_on),
        .blink_on(blink_on), .entry_inc(entry_inc), .two_line(two_line), .mode_8bit(mode_8bit),
        .overrun(overrun), .dbg_ddram_addr(dbg_ddram_addr), .dbg_ddram_data(dbg_ddram_data),
        .dbg_cgram_addr(dbg_cgram_addr), .dbg_cgram_data(dbg_cgram_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
        end
    endtask

    // Busy run length and overrun activity, sampled on the falling clock edge.
    int busy_run = 0, last_busy_len = 0, ovr_cycles = 0;
    always @(negedge clk) begin
        if (busy === 1'b1) busy_run++;
        else begin
            if (busy_run != 0) last_busy_len = busy_run;
            busy_run = 0;
        end
        if (overrun === 1'b1) ovr_cycles++;
    end

    // Reference model: addresses kept as plain numbers, RAM indexed by raw address.
    logic [7:0] m_dd [128];
    logic [7:0] m_cg [64];
    bit         m_dd_known [128];
    bit         m_cg_known [64];
    int         m_ac;
    bit         m_cgs, m_disp, m_cur, m_blink, m_inc, m_two, m_8bit;

    function automatic bit m_valid(input int a);
        return (a <= 39) || (a >= 64 && a <= 103);
    endfunction

    function automatic int m_step(input int a, input bit cg, input bit inc);
        int n;
        if (cg) return (a + (inc ? 1 : 63)) % 64;
        n = a;
        do n = inc ? (n + 1) % 128 : (n + 127) % 128; while (!m_valid(n));
        return n;
    endfunction

    task automatic m_reset();
        m_ac = 0; m_cgs = 0; m_disp = 0; m_cur = 0; m_blink = 0; m_inc = 1; m_two = 0; m_8bit = 1;
    endtask

    task automatic m_write(input bit rs, input int d);
        if (rs) begin
            if (m_cgs) begin m_cg[m_ac % 64] = 8'(d); m_cg_known[m_ac % 64] = 1; end
            else if (m_valid(m_ac)) begin m_dd[m_ac] = 8'(d); m_dd_known[m_ac] = 1; end
            m_ac = m_step(m_ac, m_cgs, m_inc);
        end else if (d >= 128) begin m_ac = d - 128; m_cgs = 0; end
        else if (d >= 64) begin m_ac = d - 64; m_cgs = 1; end
        else if (d >= 32) begin m_8bit = bit'((d / 16) % 2); m_two = bit'((d / 8) % 2); end
        else if (d >= 16) begin
            if ((d / 8) % 2 == 0) m_ac = m_step(m_ac, m_cgs, bit'((d / 4) % 2));
        end
        else if (d >= 8) begin m_disp = bit'((d / 4) % 2); m_cur = bit'((d / 2) % 2); m_blink = bit'(d % 2); end
        else if (d >= 4) m_inc = bit'((d / 2) % 2);
        else if (d >= 2) begin m_ac = 0; m_cgs = 0; end
        else if (d == 1) begin
            for (int a = 0; a < 128; a++) if (m_valid(a)) begin m_dd[a] = 8'h20; m_dd_known[a] = 1; end
            m_ac = 0; m_cgs = 0; m_inc = 1;
        end
    endtask

    function automatic logic [7:0] m_read_value();
        if (m_cgs) return m_cg[m_ac % 64];
        if (m_valid(m_ac)) return m_dd[m_ac];
        return 8'h00;
    endfunction

    function automatic logic [6:0] m_flags();
        return {m_cgs, m_disp, m_cur, m_blink, m_inc, m_two, m_8bit};
    endfunction

    function automatic logic [6:0] dut_flags();
        return {ac_is_cgram, display_on, cursor_on, blink_on, entry_inc, two_line, mode_8bit};
    endfunction

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy !== 1'b0 && n < 5000) begin @(negedge clk); n++; end
        if (n >= 5000) begin
            checks++; failures++;
            $display("FAIL wait_idle: busy=%b required=0 within 5000 clk", busy);
        end
        @(negedge clk);
    endtask

    task automatic strobe(input bit rs, input bit rw, input logic [7:0] d, output logic [7:0] q);
        @(negedge clk);
        lcd_rs = rs; lcd_rw = rw; lcd_data_in = d;
        repeat (2) @(negedge clk);
        lcd_en = 1'b1;
        repeat (6) @(negedge clk);
        q = lcd_data_out;
        lcd_en = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic bus_write(input bit rs, input logic [7:0] d);
        logic [7:0] q;
        wait_idle();
        strobe(rs, 1'b0, d, q);
    endtask

    function automatic int exp_busy_len(input bit rs, input int d);
        return (!rs && d >= 1 && d <= 3) ? HOME + 1 : CMD + 1;
    endfunction

    task automatic compare_ram(input string tag);
        for (int a = 0; a < 128; a++) begin
            if (m_valid(a) && m_dd_known[a]) begin
                dbg_ddram_addr = 7'(a); #1;
                check($sformatf("%s_ddram[%0h]", tag, a), {24'd0, dbg_ddram_data}, {24'd0, m_dd[a]});
            end
        end
        for (int a = 0; a < 64; a++) begin
            if (m_cg_known[a]) begin
                dbg_cgram_addr = 6'(a); #1;
                check($sformatf("%s_cgram[%0h]", tag, a), {24'd0, dbg_cgram_data}, {24'd0, m_cg[a]});
            end
        end
    endtask

    typedef struct {
        bit         rs;
        logic [7:0] d;
        logic [6:0] ac;
        logic [6:0] fl;  // {cg, disp, cur, blink, inc, two, 8bit}
    } vec_t;

    vec_t tbl[$];

    initial begin
        logic [7:0] q;
        int r, d, exp_len;

        #100_000_000;
        $display("FAIL watchdog: simulation did not finish actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] q;
        int r, d;

        for (int a = 0; a < 128; a++) m_dd_known[a] = 0;
        for (int a = 0; a < 64; a++) m_cg_known[a] = 0;
        m_reset();

        tbl.push_back('{0, 8'h38, 7'h00, 7'b0000111});
        tbl.push_back('{0, 8'h0C, 7'h00, 7'b0100111});
        tbl.push_back('{0, 8'h06, 7'h00, 7'b0100111});
        tbl.push_back('{0, 8'h40, 7'h00, 7'b1100111});
        tbl.push_back('{1, 8'h0E, 7'h01, 7'b1100111});
        tbl.push_back('{1, 8'h11, 7'h02, 7'b1100111});
        tbl.push_back('{1, 8'h11, 7'h03, 7'b1100111});
        tbl.push_back('{1, 8'h11, 7'h04, 7'b1100111});
        tbl.push_back('{1, 8'h1F, 7'h05, 7'b1100111});
        tbl.push_back('{1, 8'h11, 7'h06, 7'b1100111});
        tbl.push_back('{1, 8'h11, 7'h07, 7'b1100111});
        tbl.push_back('{1, 8'h00, 7'h08, 7'b1100111});
        tbl.push_back('{0, 8'h48, 7'h08, 7'b1100111});
        tbl.push_back('{1, 8'h15, 7'h09, 7'b1100111});
        tbl.push_back('{0, 8'hC0, 7'h40, 7'b0100111});
        tbl.push_back('{1, 8'h00, 7'h41, 7'b0100111});
        tbl.push_back('{1, 8'h01, 7'h42, 7'b0100111});
        tbl.push_back('{1, 8'h02, 7'h43, 7'b0100111});
        tbl.push_back('{0, 8'hA7, 7'h27, 7'b0100111});
        tbl.push_back('{1, 8'h41, 7'h40, 7'b0100111});
        tbl.push_back('{0, 8'hE7, 7'h67, 7'b0100111});
        tbl.push_back('{1, 8'h42, 7'h00, 7'b0100111});
        tbl.push_back('{0, 8'h14, 7'h01, 7'b0100111});
        tbl.push_back('{0, 8'h10, 7'h00, 7'b0100111});
        tbl.push_back('{0, 8'h10, 7'h67, 7'b0100111});
        tbl.push_back('{0, 8'h14, 7'h00, 7'b0100111});
        tbl.push_back('{0, 8'h18, 7'h00, 7'b0100111});
        tbl.push_back('{0, 8'hB0, 7'h30, 7'b0100111});
        tbl.push_back('{1, 8'h77, 7'h40, 7'b0100111});
        tbl.push_back('{0, 8'h80, 7'h00, 7'b0100111});
        tbl.push_back('{0, 8'h04, 7'h00, 7'b0100011});
        tbl.push_back('{1, 8'h33, 7'h67, 7'b0100011});
        tbl.push_back('{0, 8'h07, 7'h67, 7'b0100111});
        tbl.push_back('{0, 8'h0F, 7'h67, 7'b0111111});
        tbl.push_back('{0, 8'h28, 7'h67, 7'b0111110});
        tbl.push_back('{0, 8'h38, 7'h67, 7'b0111111});
        tbl.push_back('{0, 8'h45, 7'h05, 7'b1111111});
        tbl.push_back('{0, 8'h10, 7'h04, 7'b1111111});
        tbl.push_back('{0, 8'h02, 7'h00, 7'b0111111});
        tbl.push_back('{0, 8'h40, 7'h00, 7'b1111111});
        tbl.push_back('{0, 8'h10, 7'h3F, 7'b1111111});
        tbl.push_back('{0, 8'h14, 7'h00, 7'b1111111});

        // Reset state
        repeat (5) @(negedge clk);
        check("reset_data_out", {24'd0, lcd_data_out}, 32'h00);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_ac", {25'd0, ac}, 32'd0);
        check("reset_flags", {25'd0, dut_flags()}, {25'd0, 7'b0000101});
        check("reset_overrun", {31'd0, overrun}, 32'd0);
        reset = 1'b1;
        strobe(1'b0, 1'b1, 8'h00, q);
        check("status_after_reset", {24'd0, q}, 32'h00);

        // Directed table
        foreach (tbl[i]) begin
            bus_write(tbl[i].rs, tbl[i].d);
            m_write(tbl[i].rs, int'(tbl[i].d));
            wait_idle();
            check($sformatf("tbl%0d_ac", i), {25'd0, ac}, {25'd0, tbl[i].ac});
            check($sformatf("tbl%0d_flags", i), {25'd0, dut_flags()}, {25'd0, tbl[i].fl});
            check($sformatf("tbl%0d_busy_len", i), last_busy_len, exp_busy_len(tbl[i].rs, int'(tbl[i].d)));
        end
        compare_ram("tbl");

        // Clear: status read and overrun while busy, then full DDRAM fill
        ovr_cycles = 0;
        bus_write(1'b0, 8'h01);
        strobe(1'b0, 1'b1, 8'h00, q);
        check("status_during_clear", {24'd0, q}, 32'h80);
        strobe(1'b1, 1'b0, 8'h99, q);
        m_write(1'b0, 1);
        wait_idle();
        check("clear_busy_len", last_busy_len, HOME + 1);
        check("clear_overrun_cycles", ovr_cycles, 1);
        check("clear_ac", {25'd0, ac}, 32'd0);
        check("clear_flags", {25'd0, dut_flags()}, {25'd0, m_flags()});
        compare_ram("clear");

        // Reset in the middle of a clear
        bus_write(1'b0, 8'h01);
        m_write(1'b0, 1);
        repeat (20) @(negedge clk);
        reset = 1'b0;
        #1;
        check("midclear_reset_busy", {31'd0, busy}, 32'd0);
        check("midclear_reset_ac", {25'd0, ac}, 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        m_reset();
        bus_write(1'b0, 8'h80); m_write(1'b0, 8'h80);
        bus_write(1'b1, 8'h55); m_write(1'b1, 8'h55);
        wait_idle();
        dbg_ddram_addr = 7'h00; #1;
        check("after_reset_ddram0", {24'd0, dbg_ddram_data}, 32'h55);

        // Fill CGRAM so every cell is defined; the 64th byte wraps AC back to 0
        bus_write(1'b0, 8'h40); m_write(1'b0, 8'h40);
        for (int i = 0; i < 64; i++) begin
            d = $urandom_range(0, 255);
            bus_write(1'b1, 8'(d)); m_write(1'b1, d);
        end
        wait_idle();
        check("cgram_fill_wrap_ac", {25'd0, ac}, 32'd0);

        // Random traffic
        for (int i = 0; i < 120; i++) begin
            r = $urandom_range(0, 99);
            if (r < 35) begin
                d = (r < 2) ? $urandom_range(1, 3) : $urandom_range(4, 255);
                bus_write(1'b0, 8'(d)); m_write(1'b0, d);
                wait_idle();
                check($sformatf("rnd%0d_busy_len", i), last_busy_len, exp_busy_len(1'b0, d));
            end else if (r < 70) begin
                d = $urandom_range(0, 255);
                bus_write(1'b1, 8'(d)); m_write(1'b1, d);
                wait_idle();
                check($sformatf("rnd%0d_busy_len", i), last_busy_len, exp_busy_len(1'b1, d));
            end else if (r < 90) begin
                wait_idle();
                strobe(1'b1, 1'b1, 8'h00, q);
                check($sformatf("rnd%0d_read", i), {24'd0, q}, {24'd0, m_read_value()});
                m_ac = m_step(m_ac, m_cgs, m_inc);
            end else begin
                wait_idle();
                strobe(1'b0, 1'b1, 8'h00, q);
                check($sformatf("rnd%0d_status", i), {24'd0, q}, 32'(m_ac));
            end
            check($sformatf("rnd%0d_ac", i), {25'd0, ac}, 32'(m_ac));
            check($sformatf("rnd%0d_flags", i), {25'd0, dut_flags()}, {25'd0, m_flags()});
        end
        compare_ram("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
